// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests,
// skid-buffers one response under stall and redirects on branches.
module fetch_unit #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] STEP     = N'(4),
  parameter logic [31:0]  NOP      = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [N-1:0] fetch_pc,
  output logic [31:0]  fetch_instr,
  output logic         fetch_valid,
  output logic         flush_out
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [31:0]  instr;
  } skid_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  skid_t        skid_q, skid_d;
  logic [N-1:0] fpc_d;
  logic [31:0]  finstr_d;
  logic         fvalid_d;
  logic         flush_d;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      skid_q      <= '0;
      fetch_pc    <= '0;
      fetch_instr <= NOP;
      fetch_valid <= 1'b0;
      flush_out   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_q      <= skid_d;
      fetch_pc    <= fpc_d;
      fetch_instr <= finstr_d;
      fetch_valid <= fvalid_d;
      flush_out   <= flush_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    skid_d   = skid_q;
    fpc_d    = fetch_pc;
    finstr_d = fetch_instr;
    fvalid_d = fetch_valid;
    flush_d  = 1'b0;
    if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (branch_taken) begin
      // redirect wins over stall, skid contents and any same-cycle response
      state_d  = FETCH;
      pc_d     = {branch_target[N-1:2], 2'b00};
      skid_d   = '0;
      fvalid_d = 1'b0;
      finstr_d = NOP;
      flush_d  = 1'b1;
    end else if (state_q == HOLD) begin
      if (!stall) begin
        state_d  = FETCH;
        fpc_d    = skid_q.pc;
        finstr_d = skid_q.instr;
        fvalid_d = 1'b1;
        pc_d     = pc_q + STEP;
      end
    end else begin
      unique case (1'b1)
        imem_ready && !stall: begin
          fpc_d    = pc_q;
          finstr_d = imem_rdata;
          fvalid_d = 1'b1;
          pc_d     = pc_q + STEP;
        end
        imem_ready && stall: begin
          skid_d.pc    = pc_q;
          skid_d.instr = imem_rdata;
          state_d      = HOLD;
        end
        !imem_ready && !stall: begin
          fvalid_d = 1'b0;
          finstr_d = NOP;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a transaction-level
// model queues accepted responses, a monitor pops them as presented.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        flush_out;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_flush;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid),
    .flush_out(flush_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk),
    .rst(rst),
    .stall(1'b0),
    .branch_taken(1'b0),
    .branch_target(32'h0),
    .imem_req(w_req),
    .imem_addr(w_addr),
    .imem_ready(1'b1),
    .imem_rdata(32'h12345678),
    .fetch_pc(w_pc),
    .fetch_instr(w_instr),
    .fetch_valid(w_valid),
    .flush_out(w_flush)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       q[$];
  item_t       it;
  int          checks = 0;
  int          errors = 0;

  // model state: where the next fetch goes and whether a response is parked
  logic [31:0] mpc = '0;
  bit          running = 0;
  bit          holding = 0;
  bit          edge_chk = 0;
  bit          edge_stall = 0;
  bit          edge_branch = 0;
  bit          edge_running = 0;
  bit          did_rst = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit st, input bit br, input bit rdy,
                      input logic [31:0] tgt, input logic [31:0] data);
    bit exp_req;
    @(negedge clk);
    stall         = st;
    branch_taken  = br;
    imem_ready    = rdy;
    branch_target = tgt;
    imem_rdata    = data;
    #1;
    exp_req = running && !holding;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, mpc);
    edge_stall   = st;
    edge_branch  = br;
    edge_running = running;
    edge_chk     = 1;
    if (!running) begin
      running = 1;
    end else if (br) begin
      if (holding) void'(q.pop_back());
      holding = 0;
      mpc     = tgt & 32'hFFFFFFFC;
    end else if (holding) begin
      if (!st) begin
        holding = 0;
        mpc     = mpc + 32'd4;
      end
    end else if (rdy) begin
      q.push_back('{pc: mpc, ins: data});
      if (st) holding = 1;
      else mpc = mpc + 32'd4;
    end
  endtask

  task automatic rand_step();
    step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 7,
         $urandom_range(0, 99) < 75, $urandom, $urandom);
  endtask

  always @(posedge clk) begin
    #2;
    if (rst && edge_chk) begin
      chk("flush_out", {31'b0, flush_out},
          {31'b0, edge_branch && edge_running});
      if (edge_branch && edge_running) begin
        chk("branch_valid", {31'b0, fetch_valid}, 32'd0);
        chk("branch_instr", fetch_instr, NOP);
      end else if (!edge_stall) begin
        if (fetch_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", {31'b0, fetch_valid}, 32'd0);
          end else begin
            it = q.pop_front();
            chk("fetch_pc", fetch_pc, it.pc);
            chk("fetch_instr", fetch_instr, it.ins);
          end
        end else begin
          chk("bubble_instr", fetch_instr, NOP);
        end
      end
    end
  end

  initial begin
    @(posedge rst);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("wrap_pc0", w_pc, 32'hFFFFFFFC);
    chk("wrap_valid", {31'b0, w_valid}, 32'd1);
    chk("wrap_addr", w_addr, 32'h0);
    @(posedge clk);
    #2;
    chk("wrap_pc1", w_pc, 32'h0);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fpc", fetch_pc, 32'h0);
    chk("rst_instr", fetch_instr, NOP);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush_out}, 32'd0);
    rst = 1'b1;

    repeat (5) step(0, 0, 1, '0, $urandom);
    repeat (3) step(0, 0, 0, '0, $urandom);
    chk("wait_addr", imem_addr, 32'h10);
    repeat (4) step(0, 0, 1, '0, $urandom);
    step(1, 0, 1, '0, 32'hDEADBEEF);
    repeat (2) step(1, 0, $urandom_range(0, 1), '0, $urandom);
    step(0, 0, 1, '0, $urandom);
    step(0, 0, 1, '0, $urandom);
    step(1, 0, 1, '0, $urandom);
    step(1, 1, 1, 32'h103, $urandom);
    repeat (2) step(0, 0, 1, '0, $urandom);
    step(0, 1, 1, 32'h200, $urandom);
    step(0, 1, 1, 32'h307, $urandom);
    repeat (3) step(0, 0, 1, '0, $urandom);

    for (int i = 0; i < 2500; i++) begin
      if (!did_rst && i >= 1200 && running && !holding) begin
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("arst_flush", {31'b0, flush_out}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        edge_chk = 0;
        q.delete();
        running = 0;
        holding = 0;
        mpc     = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        did_rst = 1;
      end
      rand_step();
    end

    step(0, 0, 0, '0, $urandom);
    step(0, 0, 0, '0, $urandom);
    step(0, 0, 0, '0, $urandom);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the program counter, issues instruction-memory requests, and presents fetched instruction/PC pairs to the IF/ID pipeline register. It honours a stall from the hazard unit with a one-entry skid buffer. It redirects on taken branches and emits a one-cycle flush pulse to the downstream pipeline registers.

## Interface
- N, 32, PC / address width
- RESET_PC, 0, PC value after reset
- STEP, 4, PC increment per sequential instruction
- NOP, 32'h00000013, instruction word driven when fetch_valid=0
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; one clock domain, no other clock
- stall  in  1  hazard unit: IF/ID not accepting this cycle
- branch_taken  in  1  redirect request from EX
- branch_target  in  N  redirect address
- imem_req  out  1  instruction-memory request
- imem_addr  out  N  request address (= pc)
- imem_ready  in  1  same-cycle response; imem_rdata valid when 1
- imem_rdata  in  32  instruction word
- fetch_pc  out  N  PC of presented instruction
- fetch_instr  out  32  presented instruction
- fetch_valid  out  1  presented instruction is real (0 = bubble)
- flush_out  out  1  registered one-cycle flush to IF/ID and ID/EX

## Operation
- States: IDLE, FETCH, HOLD. Reset enters IDLE. IDLE → FETCH unconditionally on the first edge after rst deasserts.
- imem_req=1 in FETCH only. imem_addr=pc whenever imem_req=1. The PC does not change while req=1 and ready=0.
- FETCH, ready=1, stall=0: fetch_instr<=rdata, fetch_pc<=pc, fetch_valid<=1, pc<=pc+STEP. The state stays FETCH, giving 1 instruction/cycle with zero-wait memory.
- FETCH, ready=1, stall=1: rdata/pc go into the skid buffer and the state moves to HOLD. Fetch outputs hold and the PC holds.
- FETCH, ready=0, stall=0: fetch_valid<=0 and fetch_instr<=NOP (bubble). fetch_pc holds.
- FETCH, ready=0, stall=1: all outputs hold.
- HOLD: req=0. While stall=1, everything holds. When stall=0, the buffer goes to the fetch outputs with valid=1, pc<=pc+STEP, and the state moves to FETCH.
- Branch priority: branch_taken=1 in any non-IDLE state overrides all of the above.
  - pc<=branch_target with bits [1:0] forced to 0.
  - fetch_valid<=0 and fetch_instr<=NOP.
  - The skid buffer is discarded, along with any same-cycle ready response.
  - The state moves to FETCH and flush_out<=1 on the next cycle.
  - The redirect applies even when stall=1.
- flush_out is 1 for exactly one cycle per branch_taken cycle. Back-to-back branches keep it high and the last target wins.
- PC arithmetic is modulo 2^N: pc=2^N−STEP wraps to 0 with no flag.
- branch_taken in IDLE is ignored.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=0, fetch_instr=NOP, fetch_valid=0, flush_out=0, skid buffer empty.
- Reset assertion mid-operation takes effect immediately (async). Any in-flight request is abandoned and outputs return to reset values within the same cycle.
- First request is issued in cycle 1 after reset release. With ready=1 and stall=0, the first valid fetch output appears after edge 2.
- Fetch latency: edge where ready=1 and stall=0 → outputs valid after that edge (1 cycle).
- Stall release from HOLD: buffered instruction is valid after the first edge with stall=0. The next request is issued in the following cycle, giving a 1-cycle bubble.
- Branch: edge with branch_taken=1 → imem_addr=target and flush_out=1 in the next cycle. The target instruction is valid one cycle later if ready=1.
- imem_ready and imem_rdata are sampled only when imem_req=1.

## Test plan
- Reset, then ready=1 and stall=0 for 4 cycles → fetch_pc = 0, 4, 8, 12 on consecutive cycles, with fetch_valid=1 from cycle 2 onward.
- Wait states: ready=0 for 3 cycles at pc=0x10 → imem_addr holds at 0x10, fetch_valid=0 and fetch_instr=NOP. When ready=1, fetch_pc=0x10.
- Stall with skid: stall=1 while ready=1 at pc=0x20 with rdata=0xDEADBEEF → outputs hold the previous instruction and req=0 for the stall duration. On stall=0, fetch_pc=0x20 and fetch_instr=0xDEADBEEF, then the next request goes to 0x24.
- Branch during stall/HOLD: branch_taken=1 with target=0x103 → pc=0x100, flush_out=1 for one cycle, skid contents never appear, and the next valid fetch_pc=0x100.
- Wrap: RESET_PC=0xFFFFFFFC with zero-wait memory → fetch_pc goes 0xFFFFFFFC then 0x00000000.
- Reset mid-fetch: rst=0 asserted between edges while req=1 → imem_req, fetch_valid and flush_out are 0 immediately and pc=RESET_PC. After release, fetch restarts at RESET_PC.
